// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit: FSM encoding
// and the opcode field that identifies HALT.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  localparam int              OPCODE_MSB_DEF  = 31;
  localparam int              OPCODE_W_DEF    = 4;
  localparam logic [3:0]      HALT_OPCODE_DEF = 4'hF;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Decoder-side instruction stream of the fetch unit (master = fetch unit,
// slave = decoder).
interface inst_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  // Valid/ready: a beat transfers on a cycle where inst_valid && inst_ready;
  // while inst_valid is high and inst_ready low, inst_data/inst_pc hold.
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;

  modport master (
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_fifo.sv
// Prefetch FIFO of {pc, instruction} entries; head is read combinationally
// from the storage register addressed by the read pointer.
module inst_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so push into a full FIFO is legal then.
    do_push = push && (!full || do_pop);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: sequential imem reads into a prefetch FIFO, stopping
// at a count or HALT. Optional stall counter under INST_FETCH_PERF_EN.
module inst_fetch_unit
  import inst_fetch_pkg::*;
#(
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  ADDR_WIDTH  = 11,
  parameter int                  FIFO_DEPTH  = 4,
  parameter int                  OPCODE_MSB  = OPCODE_MSB_DEF,
  parameter int                  OPCODE_W    = OPCODE_W_DEF,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_inst,
  output logic                  imem_read_req,
  output logic [ADDR_WIDTH-1:0] imem_read_addr,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  inst_fetch_unit_if.master     dec,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           stall_cycles,
  output fetch_state_e          fsm_state
);
  localparam int                  FIFO_W   = ADDR_WIDTH + DATA_WIDTH;
  localparam int                  CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]      DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] MAX_INST = {1'b1, {ADDR_WIDTH{1'b0}}};

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   issued_nxt;
  logic [ADDR_WIDTH:0]   num_q;
  logic                  inflight;
  logic                  drop_q;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [FIFO_W-1:0]     fifo_head;
  logic [CNT_W:0]        credit;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  halt_hit;
  logic                  drain_done;

  always_comb begin
    // The outstanding read owns a FIFO slot, so counting it prevents overflow.
    credit     = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    issue      = (state == ST_FETCH) && (credit < DEPTH_C) && (issued < num_q);
    push       = inflight && !drop_q && (!fifo_full || pop);
    halt_hit   = push && (imem_read_data[OPCODE_MSB -: OPCODE_W] == HALT_OPCODE);
    pop        = dec.inst_valid && dec.inst_ready;
    issued_nxt = issued + {{ADDR_WIDTH{1'b0}}, issue};
    // Finish as soon as the FIFO will be empty after this edge with nothing in flight.
    drain_done = !inflight && (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));
  end

  assign imem_read_req  = issue;
  assign imem_read_addr = pc;
  assign fsm_state      = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      inflight_pc <= '0;
      issued      <= '0;
      num_q       <= '0;
      inflight    <= 1'b0;
      drop_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_WIDTH'(1);
        issued      <= issued_nxt;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q  <= (num_inst > MAX_INST) ? MAX_INST : num_inst;
            pc     <= '0;
            issued <= '0;
            drop_q <= 1'b0;
            if (num_inst == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
              busy  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          // The read issued alongside a HALT return is dropped when it lands.
          if (halt_hit) drop_q <= 1'b1;
          if (halt_hit || (issued_nxt == num_q)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (halt_hit) drop_q <= 1'b1;
          if (drain_done) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  inst_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({inflight_pc, imem_read_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign dec.inst_valid = !fifo_empty;
  assign dec.inst_data  = fifo_head[DATA_WIDTH-1:0];
  assign dec.inst_pc    = fifo_head[FIFO_W-1:DATA_WIDTH];

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if ((state == ST_IDLE) && start) begin
      stall_cycles <= '0;
    end else if (busy && dec.inst_valid && !dec.inst_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a registered imem model and an
// expected-instruction queue checked on every decoder handshake.
module tb_inst_fetch_unit;
  import inst_fetch_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 4;
  localparam int EW    = AW + DW;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic [AW:0]   num_inst = '0;
  logic          imem_read_req;
  logic [AW-1:0] imem_read_addr;
  logic [DW-1:0] imem_read_data = '0;
  logic          busy;
  logic          done;
  logic [31:0]   stall_cycles;
  fetch_state_e  fsm_state;

  inst_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dec_if ();

  inst_fetch_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_inst       (num_inst),
    .imem_read_req  (imem_read_req),
    .imem_read_addr (imem_read_addr),
    .imem_read_data (imem_read_data),
    .dec            (dec_if),
    .busy           (busy),
    .done           (done),
    .stall_cycles   (stall_cycles),
    .fsm_state      (fsm_state)
  );

  // ---------------- clock / reset / imem model ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] imem [0:(1<<AW)-1];
  always @(posedge clk) if (imem_read_req) imem_read_data <= imem[imem_read_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            done_cnt = 0;
  int            last_pop_cyc = -1;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] rd_addr_q[$];
  int            rd_cyc_q[$];
  logic [EW-1:0] pop_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (imem_read_req === 1'b1) begin
        rd_addr_q.push_back(imem_read_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (done === 1'b1) done_cnt++;
      if (dec_if.inst_valid === 1'b1 && dec_if.inst_ready === 1'b1) begin
        last_pop_cyc = cyc;
        check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          pop_exp = exp_q.pop_front();
          check("pop_pc_data", 64'({dec_if.inst_pc, dec_if.inst_data}), 64'(pop_exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), imem[i]});
  endtask

  task automatic clear_logs();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_run(input int n);
    @(posedge clk); #1;
    num_inst = (AW+1)'(n);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(at >= 0), 64'd1);
  endtask

  task automatic check_reads(input string tag, input int n);
    check({tag, "_read_count"}, 64'(rd_addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < rd_addr_q.size(); i++)
      check({tag, "_read_addr"}, 64'(rd_addr_q[i]), 64'(i));
  endtask

  // ---------------- directed sequence ----------------
  int at;
  logic [DW-1:0] saved;

  initial begin
    dec_if.inst_ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++)
      imem[i] = {4'($urandom_range(0, 14)), 28'($urandom)};

    #2 reset = 1'b0;
    tick(2);
    @(negedge clk);
    check("rst_req",   64'(imem_read_req),     64'd0);
    check("rst_addr",  64'(imem_read_addr),    64'd0);
    check("rst_valid", 64'(dec_if.inst_valid), 64'd0);
    check("rst_data",  64'(dec_if.inst_data),  64'd0);
    check("rst_pc",    64'(dec_if.inst_pc),    64'd0);
    check("rst_busy",  64'(busy),              64'd0);
    check("rst_done",  64'(done),              64'd0);
    check("rst_stall", 64'(stall_cycles),      64'd0);
    check("rst_state", 64'(fsm_state),         64'(ST_IDLE));
    tick(1);
    reset = 1'b1;
    tick(2);

    // 8 instructions, decoder always ready
    clear_logs();
    load_exp(8);
    start_run(8);
    wait_done("t1", 60, at);
    check("t1_busy_at_done", 64'(busy), 64'd0);
    check("t1_done_after_last_pop", 64'(at), 64'(last_pop_cyc + 1));
    tick(4);
    check("t1_done_once", 64'(done_cnt), 64'd1);
    check_reads("t1", 8);
    for (int i = 1; i < rd_cyc_q.size(); i++)
      check("t1_read_back_to_back", 64'(rd_cyc_q[i]), 64'(rd_cyc_q[0] + i));
    check("t1_exp_empty", 64'(exp_q.size()), 64'd0);

    // 16 instructions with decoder stalled for 20 cycles
    clear_logs();
    dec_if.inst_ready = 1'b0;
    load_exp(16);
    start_run(16);
    tick(20);
    @(negedge clk);
    check("t2_reads_while_full", 64'(rd_addr_q.size()), 64'd4);
    check("t2_req_idle_full",    64'(imem_read_req),     64'd0);
    check("t2_valid_held",       64'(dec_if.inst_valid), 64'd1);
    check("t2_pc_held",          64'(dec_if.inst_pc),    64'd0);
    check("t2_data_held",        64'(dec_if.inst_data),  64'(imem[0]));
`ifndef INST_FETCH_PERF_EN
    check("t2_stall_tied_zero",  64'(stall_cycles),      64'd0);
`endif
    tick(1);
    dec_if.inst_ready = 1'b1;
    wait_done("t2", 200, at);
    tick(3);
    check_reads("t2", 16);
    check("t2_exp_empty", 64'(exp_q.size()), 64'd0);
    check("t2_done_once", 64'(done_cnt), 64'd1);

    // HALT at address 5 out of 10
    clear_logs();
    saved    = imem[5];
    imem[5]  = {4'hF, saved[27:0]};
    load_exp(6);
    start_run(10);
    wait_done("t3", 60, at);
    tick(3);
    check_reads("t3", 7);
    check("t3_exp_empty", 64'(exp_q.size()), 64'd0);
    check("t3_done_once", 64'(done_cnt), 64'd1);
    imem[5] = saved;

    // zero-length run
    clear_logs();
    @(posedge clk); #1;
    num_inst = '0;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    @(negedge clk);
    check("t4_done",       64'(done),      64'd1);
    check("t4_busy",       64'(busy),      64'd0);
    check("t4_state_done", 64'(fsm_state), 64'(ST_DONE));
    @(negedge clk);
    check("t4_done_drop",  64'(done),      64'd0);
    check("t4_state_idle", 64'(fsm_state), 64'(ST_IDLE));
    tick(3);
    check("t4_no_reads",   64'(rd_addr_q.size()), 64'd0);
    check("t4_done_once",  64'(done_cnt),  64'd1);

    // asynchronous reset with two FIFO entries and a read in flight
    clear_logs();
    dec_if.inst_ready = 1'b0;
    start_run(16);
    tick(3);
    @(negedge clk);
    check("t5_fifo_two",   64'(dut.u_fifo.count), 64'd2);
    check("t5_valid_pre",  64'(dec_if.inst_valid), 64'd1);
    check("t5_busy_pre",   64'(busy),              64'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_valid_async", 64'(dec_if.inst_valid), 64'd0);
    check("t5_busy_async",  64'(busy),              64'd0);
    check("t5_req_async",   64'(imem_read_req),     64'd0);
    check("t5_state_async", 64'(fsm_state),         64'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b1;
    tick(2);
    clear_logs();
    exp_q.delete();
    dec_if.inst_ready = 1'b1;
    load_exp(3);
    start_run(3);
    wait_done("t5", 60, at);
    tick(3);
    check_reads("t5", 3);
    check("t5_exp_empty", 64'(exp_q.size()), 64'd0);

`ifdef INST_FETCH_PERF_EN
    // stall counter: 7 cycles of valid && !ready
    clear_logs();
    dec_if.inst_ready = 1'b0;
    load_exp(4);
    start_run(4);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dec_if.inst_valid === 1'b1) begin
        at = i;
        break;
      end
    end
    check("t6_valid_seen", 64'(at >= 0), 64'd1);
    repeat (7) @(posedge clk);
    #1 dec_if.inst_ready = 1'b1;
    wait_done("t6", 60, at);
    check("t6_stall_at_done", 64'(stall_cycles), 64'd7);
    tick(3);
    check("t6_stall_hold",    64'(stall_cycles), 64'd7);
    check("t6_exp_empty",     64'(exp_q.size()), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
